// File: rtl/sync_sp_ram_arb.sv
// sync_sp_ram_arb: arbiter and sequencer sharing one synchronous single-port RAM between NUM_PORTS requesters.
//   Clk_CI, Rst_RI (async, active-high)
//   Req_SI/Gnt_SO/WrEn_SI/Addr_DI/WrData_DI : per-port request side, grant means issued this cycle
//   RValid_SO/RdData_DO                     : per-port response valid, shared read data, RAM_LAT after grant
//   RamCSel_SO/RamWrEn_SO/RamAddr_DO/RamWrData_DO/RamRdData_DI : single-port RAM side
//   Define SP_RAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module sync_sp_ram_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REGS   = 0
) (
  input  logic                                 Clk_CI,
  input  logic                                 Rst_RI,
  input  logic [NUM_PORTS-1:0]                 Req_SI,
  output logic [NUM_PORTS-1:0]                 Gnt_SO,
  input  logic [NUM_PORTS-1:0]                 WrEn_SI,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] Addr_DI,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] WrData_DI,
  output logic [NUM_PORTS-1:0]                 RValid_SO,
  output logic [DATA_WIDTH-1:0]                RdData_DO,
  output logic                                 RamCSel_SO,
  output logic                                 RamWrEn_SO,
  output logic [ADDR_WIDTH-1:0]                RamAddr_DO,
  output logic [DATA_WIDTH-1:0]                RamWrData_DO,
  input  logic [DATA_WIDTH-1:0]                RamRdData_DI
);
  localparam int RAM_LAT = 1 + ((OUT_REGS > 0) ? 1 : 0);
  localparam int PW = $clog2(NUM_PORTS);
  logic [NUM_PORTS-1:0] req;
  logic [PW-1:0] Ptr_SP, gnt_id, idx;
  logic gnt_v;
  logic [RAM_LAT-1:0] pipe_v, pipe_we;
  logic [RAM_LAT-1:0][PW-1:0] pipe_id;
  // reset gates arbitration so nothing reaches the RAM while held in reset
  assign req = Rst_RI ? '0 : Req_SI;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
  assign Ptr_SP = '0;
`else
  always_ff @(posedge Clk_CI or posedge Rst_RI)
    if (Rst_RI) Ptr_SP <= '0;
    else if (gnt_v) Ptr_SP <= (gnt_id == PW'(NUM_PORTS - 1)) ? '0 : gnt_id + 1'b1;
`endif
  // first requester found scanning upward from the pointer, wrapping modulo NUM_PORTS
  always_comb begin
    gnt_v = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = PW'((int'(Ptr_SP) + k) % NUM_PORTS);
      if (!gnt_v && req[idx]) begin
        gnt_v = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign Gnt_SO       = gnt_v ? (NUM_PORTS'(1) << gnt_id) : '0;
  assign RamCSel_SO   = |req;
  assign RamWrEn_SO   = gnt_v ? WrEn_SI[gnt_id] : 1'b0;
  assign RamAddr_DO   = gnt_v ? Addr_DI[gnt_id] : '0;
  assign RamWrData_DO = gnt_v ? WrData_DI[gnt_id] : '0;
  // response pipeline tracks each issued access for exactly RAM_LAT cycles
  always_ff @(posedge Clk_CI or posedge Rst_RI)
    if (Rst_RI) begin
      pipe_v  <= '0;
      pipe_we <= '0;
      pipe_id <= '0;
    end else begin
      for (int s = RAM_LAT - 1; s > 0; s--) begin
        pipe_v[s]  <= pipe_v[s-1];
        pipe_we[s] <= pipe_we[s-1];
        pipe_id[s] <= pipe_id[s-1];
      end
      pipe_v[0]  <= gnt_v;
      pipe_we[0] <= gnt_v & WrEn_SI[gnt_id];
      pipe_id[0] <= gnt_id;
    end
  assign RValid_SO = pipe_v[RAM_LAT-1] ? (NUM_PORTS'(1) << pipe_id[RAM_LAT-1]) : '0;
  assign RdData_DO = (pipe_v[RAM_LAT-1] && !pipe_we[RAM_LAT-1]) ? RamRdData_DI : '0;
endmodule
